// File: rtl/anita_trig_pkg.sv
// Shared definitions for the ANITA multi-channel trigger synchroniser.
// Holds the per-channel state encoding, the default parameter values and a
// constant clog2 helper used to size the scaler readout select.
package anita_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_HOLD  = 2'd3
    } trig_state_e;

    localparam int DEF_NCH        = 8;
    localparam int DEF_SYNC_DEPTH = 3;
    localparam int DEF_HOLDOFF_W  = 4;
    localparam int DEF_SCALER_W   = 16;

    // Smallest n with 2**n >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/anita_trig_chan.sv
// One trigger channel: synchroniser chain, event state machine, holdoff
// down-counter and live/snapshot scaler pair.
//
// Ports
//   clk, rst_n       clock and (already bridged) async active-low reset
//   trig_latch_i     async level from the external falling-edge latch
//   mask_i           1 = suppress pulse and count for this event
//   holdoff_i        dead cycles after the latch is released
//   scaler_latch_i   snapshot-and-clear strobe for the scaler
//   latch_clr_o      clear to the external latch
//   trig_pulse_o     one-cycle pulse per accepted, unmasked event
//   busy_o           state machine not in IDLE
//   live_o, snap_o   live scaler count and last snapshot
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for the synchronised latch level to go high
// ST_FIRE  | single cycle: pulse (if unmasked) and start clearing latch
// ST_CLEAR | latch clear held until the released level comes through
// ST_HOLD  | holdoff dead time, synchronised level ignored
module anita_trig_chan
    import anita_trig_pkg::*;
#(
    parameter int SYNC_DEPTH = DEF_SYNC_DEPTH,
    parameter int HOLDOFF_W  = DEF_HOLDOFF_W,
    parameter int SCALER_W   = DEF_SCALER_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trig_latch_i,
    input  logic                 mask_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    input  logic                 scaler_latch_i,
    output logic                 latch_clr_o,
    output logic                 trig_pulse_o,
    output logic                 busy_o,
    output logic [SCALER_W-1:0]  live_o,
    output logic [SCALER_W-1:0]  snap_o
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_DEPTH-1:0] sync_q;
    logic [SYNC_DEPTH-1:0] sync_d;
    trig_state_e           state_q, state_d;
    logic [HOLDOFF_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic                  latch_clr_q, latch_clr_d;
    logic                  trig_pulse_q, trig_pulse_d;
    logic [SCALER_W-1:0]   live_q, live_d;
    logic [SCALER_W-1:0]   snap_q, snap_d;
    logic                  sync_lvl;
    logic                  fire_evt;

    // Stage 0 may be metastable; only the last stage feeds logic.
    assign sync_lvl = sync_q[SYNC_DEPTH-1];

    always_comb begin
        sync_d       = {sync_q[SYNC_DEPTH-2:0], trig_latch_i};
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        latch_clr_d  = latch_clr_q;
        trig_pulse_d = 1'b0;
        live_d       = live_q;
        snap_d       = snap_q;

        // Mask is judged on the edge that enters FIRE, the same edge that
        // registers the pulse and bumps the scaler.
        fire_evt = (state_q == ST_IDLE) && sync_lvl && !mask_i;

        case (state_q)
            ST_IDLE: begin
                if (sync_lvl) begin
                    state_d      = ST_FIRE;
                    latch_clr_d  = 1'b1;
                    trig_pulse_d = !mask_i;
                end
            end
            ST_FIRE: begin
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (!sync_lvl) begin
                    latch_clr_d = 1'b0;
                    if (holdoff_i == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = holdoff_i - HOLDOFF_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                latch_clr_d = 1'b0;
            end
        endcase

        // A fire coinciding with the snapshot strobe starts the new count at 1.
        if (scaler_latch_i) begin
            snap_d = live_q;
            live_d = fire_evt ? SCALER_W'(1) : '0;
        end else if (fire_evt && (live_q != '1)) begin
            live_d = live_q + SCALER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            latch_clr_q  <= 1'b0;
            trig_pulse_q <= 1'b0;
            live_q       <= '0;
            snap_q       <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            latch_clr_q  <= latch_clr_d;
            trig_pulse_q <= trig_pulse_d;
            live_q       <= live_d;
            snap_q       <= snap_d;
        end
    end

    assign latch_clr_o  = latch_clr_q;
    assign trig_pulse_o = trig_pulse_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign live_o       = live_q;
    assign snap_o       = snap_q;

endmodule

// File: rtl/anita_trig_sync_multi.sv
// Multi-channel trigger synchroniser for the SURF trigger path. Brings NCH
// asynchronous trigger latches into the CLK domain, pulses once per event,
// clears the external latches, and keeps per-channel saturating scalers.
//
// Ports
//   CLK, CLR_N     trigger clock, async active-low reset
//   TRIG_LATCH     per-channel async latch levels
//   MASK           per-channel mask (1 = no pulse, no count)
//   HOLDOFF        dead cycles after latch release
//   SCALER_LATCH   snapshot-and-clear strobe for all scalers
//   SCALER_SEL     snapshot readout select
//   LATCH_CLR      clears to the external latches
//   TRIG_PULSE     one-cycle event pulses
//   PAIR_COINC     channels 2k and 2k+1 pulsed in the same cycle
//   BUSY           channel not idle
//   SCALER_DATA    selected snapshot, registered
module anita_trig_sync_multi
    import anita_trig_pkg::*;
#(
    parameter int NCH        = DEF_NCH,
    parameter int SYNC_DEPTH = DEF_SYNC_DEPTH,
    parameter int HOLDOFF_W  = DEF_HOLDOFF_W,
    parameter int SCALER_W   = DEF_SCALER_W
) (
    input  logic                    CLK,
    input  logic                    CLR_N,
    input  logic [NCH-1:0]          TRIG_LATCH,
    input  logic [NCH-1:0]          MASK,
    input  logic [HOLDOFF_W-1:0]    HOLDOFF,
    input  logic                    SCALER_LATCH,
    input  logic [clog2(NCH)-1:0]   SCALER_SEL,
    output logic [NCH-1:0]          LATCH_CLR,
    output logic [NCH-1:0]          TRIG_PULSE,
    output logic [NCH/2-1:0]        PAIR_COINC,
    output logic [NCH-1:0]          BUSY,
    output logic [SCALER_W-1:0]     SCALER_DATA
);

    localparam int SEL_W = clog2(NCH);

    logic [1:0]          rst_pipe_q, rst_pipe_d;
    logic                rst_sync_n;
    logic [SCALER_W-1:0] live_all [NCH];
    logic [SCALER_W-1:0] snap_all [NCH];
    logic [NCH/2-1:0]    pair_coinc_q, pair_coinc_d;
    logic [SCALER_W-1:0] scaler_data_q, scaler_data_d;

    // Reset asserts asynchronously, releases two clean edges later.
    assign rst_pipe_d = {rst_pipe_q[0], 1'b1};

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            rst_pipe_q <= '0;
        end else begin
            rst_pipe_q <= rst_pipe_d;
        end
    end

    assign rst_sync_n = rst_pipe_q[1];

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        anita_trig_chan #(
            .SYNC_DEPTH (SYNC_DEPTH),
            .HOLDOFF_W  (HOLDOFF_W),
            .SCALER_W   (SCALER_W)
        ) u_chan (
            .clk            (CLK),
            .rst_n          (rst_sync_n),
            .trig_latch_i   (TRIG_LATCH[g]),
            .mask_i         (MASK[g]),
            .holdoff_i      (HOLDOFF),
            .scaler_latch_i (SCALER_LATCH),
            .latch_clr_o    (LATCH_CLR[g]),
            .trig_pulse_o   (TRIG_PULSE[g]),
            .busy_o         (BUSY[g]),
            .live_o         (live_all[g]),
            .snap_o         (snap_all[g])
        );
    end

    always_comb begin
        pair_coinc_d  = '0;
        scaler_data_d = '0;
        for (int k = 0; k < NCH / 2; k++) begin
            pair_coinc_d[k] = TRIG_PULSE[2*k] & TRIG_PULSE[2*k+1];
        end
        // During the snapshot strobe the live value is the one being captured,
        // so forward it to keep readout one cycle after the strobe.
        for (int i = 0; i < NCH; i++) begin
            if (SCALER_SEL == SEL_W'(i)) begin
                scaler_data_d = SCALER_LATCH ? live_all[i] : snap_all[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pair_coinc_q  <= '0;
            scaler_data_q <= '0;
        end else begin
            pair_coinc_q  <= pair_coinc_d;
            scaler_data_q <= scaler_data_d;
        end
    end

    assign PAIR_COINC  = pair_coinc_q;
    assign SCALER_DATA = scaler_data_q;

endmodule
